instr_fetch_unit: RTL

Instruction fetch stage that sits directly upstream of the Processor datapath/decode. It holds the PC and issues word reads to instruction memory over a req/ack handshake. It presents each fetched instruction with its PC to the Processor over a valid/ready handshake, and accepts branch/jump redirects from the Processor.

---
 rtl/instr_fetch_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, reads instruction memory over req/ack and
// hands instructions to the decoder over valid/ready. Define FETCH_PREFETCH_EN for a 2-entry prefetch buffer.
module instr_fetch_unit #(
    parameter int unsigned             PC_WIDTH    = 16,
    parameter int unsigned             INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0
) (
    input  logic                   Clk,
    input  logic                   Reset,
    output logic                   MemReq,
    output logic [PC_WIDTH-1:0]    MemAddr,
    input  logic                   MemAck,
    input  logic [INSTR_WIDTH-1:0] MemData,
    output logic                   InstrValid,
    input  logic                   InstrReady,
    output logic [INSTR_WIDTH-1:0] Instr,
    output logic [PC_WIDTH-1:0]    InstrPC,
    input  logic                   Redirect,
    input  logic [PC_WIDTH-1:0]    RedirectPC
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]             state_reg, state_next;
    logic [PC_WIDTH-1:0]    pc_reg, pc_next;
    logic                   start_reg;
    logic                   valid_reg, valid_next;
    logic [INSTR_WIDTH-1:0] instr_reg, instr_next;
    logic [PC_WIDTH-1:0]    instr_pc_reg, instr_pc_next;

`ifdef FETCH_PREFETCH_EN
    logic                   buf_valid_reg, buf_valid_next;
    logic [INSTR_WIDTH-1:0] buf_instr_reg, buf_instr_next;
    logic [PC_WIDTH-1:0]    buf_pc_reg, buf_pc_next;

    // Keep requesting until both the output register and the second entry are occupied.
    assign MemReq = (state_reg != ST_IDLE) && !(valid_reg && buf_valid_reg);
`else
    assign MemReq = (state_reg == ST_REQ);
`endif

    assign MemAddr    = pc_reg;
    assign InstrValid = valid_reg;
    assign Instr      = instr_reg;
    assign InstrPC    = instr_pc_reg;

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        valid_next    = valid_reg;
        instr_next    = instr_reg;
        instr_pc_next = instr_pc_reg;
`ifdef FETCH_PREFETCH_EN
        buf_valid_next = buf_valid_reg;
        buf_instr_next = buf_instr_reg;
        buf_pc_next    = buf_pc_reg;
`endif
        if (Redirect) begin
            // Flush everything; any ack arriving this cycle belongs to the old stream.
            pc_next    = RedirectPC;
            valid_next = 1'b0;
            state_next = ST_REQ;
`ifdef FETCH_PREFETCH_EN
            buf_valid_next = 1'b0;
`endif
        end else if (state_reg == ST_IDLE) begin
            if (start_reg) begin
                state_next = ST_REQ;
            end
        end else begin
`ifdef FETCH_PREFETCH_EN
            if (valid_reg && InstrReady) begin
                if (buf_valid_reg) begin
                    instr_next     = buf_instr_reg;
                    instr_pc_next  = buf_pc_reg;
                    buf_valid_next = 1'b0;
                end else begin
                    valid_next = 1'b0;
                end
            end
            // Fill after draining so a simultaneous pop/push keeps FIFO order.
            if (MemReq && MemAck) begin
                pc_next = pc_reg + PC_ONE;
                if (!valid_next) begin
                    instr_next    = MemData;
                    instr_pc_next = pc_reg;
                    valid_next    = 1'b1;
                end else begin
                    buf_instr_next = MemData;
                    buf_pc_next    = pc_reg;
                    buf_valid_next = 1'b1;
                end
            end
            state_next = valid_next ? ST_HOLD : ST_REQ;
`else
            case (state_reg)
                ST_REQ: begin
                    if (MemAck) begin
                        instr_next    = MemData;
                        instr_pc_next = pc_reg;
                        valid_next    = 1'b1;
                        pc_next       = pc_reg + PC_ONE;
                        state_next    = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (InstrReady) begin
                        valid_next = 1'b0;
                        state_next = ST_REQ;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
`endif
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg    <= ST_IDLE;
            pc_reg       <= RESET_PC;
            start_reg    <= 1'b0;
            valid_reg    <= 1'b0;
            instr_reg    <= '0;
            instr_pc_reg <= '0;
`ifdef FETCH_PREFETCH_EN
            buf_valid_reg <= 1'b0;
            buf_instr_reg <= '0;
            buf_pc_reg    <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            start_reg    <= 1'b1;
            valid_reg    <= valid_next;
            instr_reg    <= instr_next;
            instr_pc_reg <= instr_pc_next;
`ifdef FETCH_PREFETCH_EN
            buf_valid_reg <= buf_valid_next;
            buf_instr_reg <= buf_instr_next;
            buf_pc_reg    <= buf_pc_next;
`endif
        end
    end

endmodule
